// File: rtl/alarm_multi_compare_pkg.sv
// alarm_pkg: shared types and widths for the multi-channel alarm unit.
//   bcd_t         - one BCD digit
//   hhmm_t        - packed HH:MM alarm/clock time (hourH, hourL, minH, minL)
//   alarm_state_t - per-channel state: OFF, ARMED, RINGING, SNOOZED
//   RING_CNT_W / SNZ_CNT_W - ring and snooze counter widths
package alarm_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t hourH;
    bcd_t hourL;
    bcd_t minH;
    bcd_t minL;
  } hhmm_t;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZED = 2'd3
  } alarm_state_t;

  localparam int RING_CNT_W = 8;
  localparam int SNZ_CNT_W  = 4;

endpackage

// File: rtl/alarm_multi_compare_if.sv
// alarm_multi_compare_if: control, time and status bundle for alarm_multi_compare.
//   master: drives tick_sec, mode enables, channel write bus, current time,
//           stop/snooze; observes ring, ring_idx, armed.
//   slave : the alarm unit side (directions reversed).
interface alarm_multi_compare_if #(
  parameter int N_ALARM = 4
);
  import alarm_pkg::*;

  localparam int IW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;

  logic               tick_sec;
  logic               EN_work;
  logic               EN_setalarm;
  logic               set_we;
  logic [IW-1:0]      set_idx;
  logic               set_arm;
  bcd_t               set_minL, set_minH, set_hourL, set_hourH;
  bcd_t               now_minL, now_minH, now_hourL, now_hourH;
  logic               stop;
  logic               snooze;
  logic               ring;
  logic [IW-1:0]      ring_idx;
  logic [N_ALARM-1:0] armed;

  modport master (
    output tick_sec, EN_work, EN_setalarm, set_we, set_idx, set_arm,
           set_minL, set_minH, set_hourL, set_hourH,
           now_minL, now_minH, now_hourL, now_hourH, stop, snooze,
    input  ring, ring_idx, armed
  );

  modport slave (
    input  tick_sec, EN_work, EN_setalarm, set_we, set_idx, set_arm,
           set_minL, set_minH, set_hourL, set_hourH,
           now_minL, now_minH, now_hourL, now_hourH, stop, snooze,
    output ring, ring_idx, armed
  );

endinterface

// File: rtl/alarm_multi_compare_channel.sv
// alarm_channel: one alarm channel - stored HH:MM, arm state, ring/snooze FSM.
// Optional macro ALARM_SNOOZE_EN builds the SNOOZED state and snooze counter.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   tick_sec     - one-cycle seconds pulse (ring timer)
//   compare_en   - time comparison enabled
//   now          - current time
//   min_roll     - current-minute digit changed this cycle (snooze timer)
//   stop, snooze - dismiss / snooze requests
//   set_we       - write strobe already decoded for this channel
//   set_arm, set_time - written arm bit and alarm time
//   ringing      - channel is in RINGING
//   armed        - channel arm bit (state other than OFF)
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  tick_sec,
  input  logic  compare_en,
  input  hhmm_t now,
  input  logic  min_roll,
  input  logic  stop,
  input  logic  snooze,
  input  logic  set_we,
  input  logic  set_arm,
  input  hhmm_t set_time,
  output logic  ringing,
  output logic  armed
);

  localparam logic [RING_CNT_W-1:0] RING_LAST = RING_CNT_W'(RING_SECS - 1);

  alarm_state_t          state;
  hhmm_t                 alarm_time;
  logic                  match_q;
  logic                  match;
  logic [RING_CNT_W-1:0] ring_cnt;

`ifdef ALARM_SNOOZE_EN
  localparam logic [SNZ_CNT_W-1:0] SNZ_LAST = SNZ_CNT_W'(SNOOZE_MIN - 1);
  logic [SNZ_CNT_W-1:0] snz_cnt;
`else
  logic unused_snz;
  assign unused_snz = snooze ^ min_roll;
`endif

  assign armed   = (state != OFF);
  assign ringing = (state == RINGING);
  assign match   = compare_en && armed && (alarm_time == now);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= OFF;
      alarm_time <= '0;
      match_q    <= 1'b0;
      ring_cnt   <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt    <= '0;
`endif
    end else if (set_we) begin
      // Seeding match_q with the new compare result keeps a write of the
      // current time from firing within that minute.
      alarm_time <= set_time;
      match_q    <= compare_en && set_arm && (set_time == now);
      state      <= set_arm ? ARMED : OFF;
      ring_cnt   <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt    <= '0;
`endif
    end else begin
      match_q <= match;
      case (state)
        OFF: ;
        ARMED: begin
          if (match && !match_q) begin
            state    <= RINGING;
            ring_cnt <= '0;
          end
        end
        RINGING: begin
          if (stop) begin
            state <= ARMED;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze) begin
            state   <= SNOOZED;
            snz_cnt <= '0;
`endif
          end else if (tick_sec) begin
            if (ring_cnt == RING_LAST) state <= ARMED;
            else                       ring_cnt <= ring_cnt + 1'b1;
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZED: begin
          if (stop) begin
            state <= ARMED;
          end else if (min_roll) begin
            if (snz_cnt == SNZ_LAST) begin
              state    <= RINGING;
              ring_cnt <= '0;
              snz_cnt  <= SNZ_CNT_W'(SNOOZE_MIN);
            end else begin
              snz_cnt <= snz_cnt + 1'b1;
            end
          end
        end
`endif
        default: state <= OFF;
      endcase
    end
  end

endmodule

// File: rtl/alarm_multi_compare.sv
// alarm_multi_compare: N-channel BCD HH:MM alarm unit.
// Optional macro ALARM_SNOOZE_EN enables the per-channel snooze function;
// without it the snooze input is ignored.
// Ports:
//   CLK   - system clock
//   RST_n - synchronous active-low reset
//   bus   - alarm_multi_compare_if.slave: tick_sec, EN_work, EN_setalarm,
//           channel write bus (set_*), current time (now_*), stop, snooze;
//           outputs ring, ring_idx (lowest ringing channel), armed.
module alarm_multi_compare
  import alarm_pkg::*;
#(
  parameter int N_ALARM    = 4,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  alarm_multi_compare_if.slave  bus
);

  localparam int IW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;

  logic               compare_en;
  hhmm_t              now_t;
  hhmm_t              set_t;
  bcd_t               minL_q;
  logic               min_roll;
  logic [N_ALARM-1:0] ringing;
  logic [N_ALARM-1:0] armed_v;
  logic [IW-1:0]      ring_idx_c;

  assign compare_en = !bus.EN_work && !bus.EN_setalarm;
  assign now_t = '{hourH: bus.now_hourH, hourL: bus.now_hourL,
                   minH: bus.now_minH, minL: bus.now_minL};
  assign set_t = '{hourH: bus.set_hourH, hourL: bus.set_hourL,
                   minH: bus.set_minH, minL: bus.set_minL};

  always_ff @(posedge CLK) begin
    if (!RST_n) minL_q <= '0;
    else        minL_q <= bus.now_minL;
  end

  assign min_roll = (bus.now_minL != minL_q);

  for (genvar g = 0; g < N_ALARM; g++) begin : g_ch
    alarm_channel #(
      .RING_SECS (RING_SECS),
      .SNOOZE_MIN(SNOOZE_MIN)
    ) u_ch (
      .clk       (CLK),
      .rst_n     (RST_n),
      .tick_sec  (bus.tick_sec),
      .compare_en(compare_en),
      .now       (now_t),
      .min_roll  (min_roll),
      .stop      (bus.stop),
      .snooze    (bus.snooze),
      .set_we    (bus.set_we && (bus.set_idx == IW'(g))),
      .set_arm   (bus.set_arm),
      .set_time  (set_t),
      .ringing   (ringing[g]),
      .armed     (armed_v[g])
    );
  end

  // Scan from the top down so the lowest ringing index wins.
  always_comb begin
    ring_idx_c = '0;
    for (int unsigned i = N_ALARM; i > 0; i--) begin
      if (ringing[i-1]) ring_idx_c = IW'(i - 1);
    end
  end

  assign bus.ring     = |ringing;
  assign bus.ring_idx = ring_idx_c;
  assign bus.armed    = armed_v;

endmodule

// File: doc/alarm_multi_compare.md
Name: alarm_multi_compare

Overview:
- N-channel alarm unit. Each channel stores a BCD HH:MM alarm time, an arm bit, and its own ring/snooze state machine.
- It compares every armed channel against the running clock time and drives a shared ring output plus the index of the ringing channel.
- It sits between the time-keeping counter and the buzzer/display logic. It supersedes the single-channel, level-compare alarm.

Parameters:
- N_ALARM, 4, number of alarm channels (1..8).
- RING_SECS, 60, tick_sec pulses a channel rings before auto-dismiss (1..255).
- SNOOZE_MIN, 5, minutes a snoozed channel waits before re-ringing (1..15).

Ports:
- CLK  in  1  system clock
- RST_n  in  1  synchronous active-low reset
- tick_sec  in  1  one-CLK pulse per second from the time base
- EN_work  in  1  1 = clock-setting mode; comparison suspended
- EN_setalarm  in  1  1 = alarm-setting mode; comparison suspended
- set_we  in  1  write strobe for channel set_idx
- set_idx  in  clog2(N_ALARM) (min 1)  channel to write
- set_arm  in  1  arm value written with set_we
- set_minL, set_minH, set_hourL, set_hourH  in  4 each  BCD alarm time written with set_we
- now_minL, now_minH, now_hourL, now_hourH  in  4 each  current BCD time
- stop  in  1  dismiss all ringing/snoozed channels
- snooze  in  1  snooze all ringing channels
- ring  out  1  OR of all channels in RINGING
- ring_idx  out  clog2(N_ALARM) (min 1)  lowest-index ringing channel; 0 when ring=0
- armed  out  N_ALARM  per-channel arm bit

Behaviour:
- Reset (RST_n=0 at a CLK edge):
  - All channels go to OFF; stored times = 00:00.
  - armed=0, ring=0, ring_idx=0.
  - All counters cleared; match history cleared.
- compare_en = !EN_work && !EN_setalarm.
- match[i] = compare_en && armed[i] && all four stored digits equal the now_* digits.
- Trigger uses the rising edge of match[i] (registered match_q[i]). A channel fires once per matching minute; a dismissal inside the same minute does not re-fire it.
- Per-channel states:
  - OFF: armed=0. A set_we with set_arm=1 goes to ARMED.
  - ARMED: on match rising edge, go to RINGING and clear ring_cnt.
  - RINGING:
    - ring_cnt increments on tick_sec.
    - When ring_cnt reaches RING_SECS-1 and tick_sec=1, go to ARMED.
    - stop goes to ARMED.
    - snooze goes to SNOOZED and clears snz_cnt.
  - SNOOZED:
    - snz_cnt increments on each minute rollover (now_minL differs from its registered value).
    - When snz_cnt reaches SNOOZE_MIN, go to RINGING with ring_cnt cleared.
    - stop goes to ARMED.
- Writes:
  - set_we to channel i overwrites the time and arm bit in any state, one-cycle latency.
  - set_arm=0 goes to OFF immediately, even from RINGING or SNOOZED.
  - set_arm=1 from RINGING or SNOOZED goes to ARMED.
  - match_q[i] is loaded with the new compare result, so writing the current time does not fire that minute.
- Latency: ring rises one CLK after the cycle in which the match condition first becomes true.
- Simultaneous events:
  - stop beats snooze.
  - set_we beats stop, snooze and trigger for the written channel.
  - Timeout and stop in the same cycle both go to ARMED.
- Several channels may ring at once; ring_idx uses lowest-index priority.
- compare_en=0 freezes triggers only. Ring and snooze timers keep running.
- Counter widths: ring_cnt is 8 bits, snz_cnt is 4 bits; neither wraps past its terminal value.
- ring_idx is fully combinational from the registered states. All other outputs are registered.

Optional Feature:
- Macro: ALARM_SNOOZE_EN.
- Defined: SNOOZED state, snz_cnt and snooze input behave as above.
- Undefined:
  - SNOOZED state and snz_cnt are not built; the snooze port remains but is ignored.
  - RINGING exits only by timeout, stop or write.

Decomposition:
- Package alarm_pkg:
  - bcd_t (4-bit digit).
  - hhmm_t struct (hourH, hourL, minH, minL).
  - alarm_state_t enum {OFF, ARMED, RINGING, SNOOZED}.
  - Widths for ring_cnt and snz_cnt.
- Sub-module alarm_channel holds one channel's storage, FSM and counters. The top module generates N_ALARM instances, the minute-rollover detector and the ring_idx priority encoder.

Test Plan:
- Reset then arm ch2 at 07:30, drive now=07:29->07:30 with compare_en=1 -> ring=1, ring_idx=2 one CLK after now changes; armed=4'b0100.
- Ch2 ringing, pulse stop at 07:30 -> ring=0 next CLK; no re-fire for the rest of 07:30; fires again at the next day's 07:30.
- Ch2 ringing, apply 60 tick_sec pulses -> ring falls after the 60th; state ARMED.
- ALARM_SNOOZE_EN defined: snooze at 07:30 -> ring=0; after 5 minute rollovers (07:35) -> ring=1, ring_idx=2. Undefined: snooze has no effect.
- Ch0 and ch3 both set to 12:00 -> ring_idx=0; stop dismisses both; EN_work=1 at 12:00 -> no ring.
- While ch1 is ringing, set_we ch1 with set_arm=0 -> ring=0 and armed[1]=0 next CLK. Assert RST_n=0 while ringing -> all outputs 0 next CLK.
